// File: rtl/sram_responder_if.sv
// SRAM control/status bundle between a memory-stage controller and the
// sram_responder model. The bidirectional data bus stays a plain module port.
interface sram_responder_if;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        busy;
    logic        proto_err;
    logic [7:0]  err_count;

    // Controller side: drives SRAM controls, observes responder status.
    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N,
        input  busy, proto_err, err_count
    );

    // Responder side: samples SRAM controls, reports status.
    modport slave (
        input  SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N,
        output busy, proto_err, err_count
    );
endinterface

// File: rtl/sram_responder.sv
// Behavioural async-SRAM responder: 16-bit words with byte-lane writes,
// programmable read latency, tri-state data bus and protocol-error counting.
module sram_responder #(
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [15:0]       SRAM_DQ,
    sram_responder_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nx;
    logic [17:0]   r_rd_addr;
    logic [17:0]   w_rd_addr_nx;
    logic [15:0]   r_rd_data;
    logic [15:0]   w_rd_data_nx;
    logic          r_proto_err;
    logic [7:0]    r_err_count;
    logic          w_load;
    logic          w_start;
    logic [AW-1:0] w_load_idx;
    logic [AW-1:0] w_idx;
    logic [15:0]   w_rd_word;
    logic          w_ce;
    logic          w_wr;
    logic          w_rd_req;
    logic          w_addr_chg;
    logic          w_perr;
    logic          w_dq_oe;

    // Storage array; deliberately has no reset.
    logic [15:0]   r_mem [DEPTH];

    // Upper address bits are ignored for array indexing (aliasing).
    assign w_idx      = bus.SRAM_ADDR[AW-1:0];
    assign w_ce       = ~bus.SRAM_CE_N;
    assign w_wr       = w_ce & ~bus.SRAM_WE_N;
    assign w_rd_req   = w_ce & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
    assign w_addr_chg = (bus.SRAM_ADDR != r_rd_addr);
    assign w_perr     = w_wr & ~bus.SRAM_OE_N;

    // Read data source and lane masking applied at the load edge.
    assign w_rd_word    = r_mem[w_load_idx];
    assign w_rd_data_nx = {bus.SRAM_UB_N ? 8'h00 : w_rd_word[15:8],
                           bus.SRAM_LB_N ? 8'h00 : w_rd_word[7:0]};

    // Next-state, latency counter and read-address/data-load decisions.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_rd_addr_nx = r_rd_addr;
        w_load       = 1'b0;
        w_start      = 1'b0;
        w_load_idx   = r_rd_addr[AW-1:0];

        if (!w_ce) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else if (w_wr) begin
            w_state_nx = WR;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                RD_WAIT, RD_DRIVE: begin
                    if (!w_rd_req) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_addr_chg) begin
                        w_start = 1'b1;
                    end else if (r_state == RD_WAIT) begin
                        if (r_cnt == 3'd1) begin
                            w_load     = 1'b1;
                            w_state_nx = RD_DRIVE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx = r_cnt - 3'd1;
                        end
                    end
                end
                // IDLE, and WR on an edge without a further write
                default: begin
                    if (w_rd_req) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
                end
            endcase
        end

        // New read request or address change: (re)latch and restart latency.
        if (w_start) begin
            w_rd_addr_nx = bus.SRAM_ADDR;
            if (RD_LAT == 1) begin
                w_load     = 1'b1;
                w_load_idx = w_idx;
                w_state_nx = RD_DRIVE;
                w_cnt_nx   = '0;
            end else begin
                w_state_nx = RD_WAIT;
                w_cnt_nx   = 3'(RD_LAT - 1);
            end
        end
    end

    // FSM state, read pipeline registers and protocol-error bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            r_proto_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_rd_addr   <= w_rd_addr_nx;
            if (w_load) begin
                r_rd_data <= w_rd_data_nx;
            end
            r_proto_err <= w_perr;
            if (w_perr && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Byte-lane array write; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && w_wr) begin
            if (!bus.SRAM_UB_N) begin
                r_mem[w_idx][15:8] <= SRAM_DQ[15:8];
            end
            if (!bus.SRAM_LB_N) begin
                r_mem[w_idx][7:0] <= SRAM_DQ[7:0];
            end
        end
    end

    // Drive enable is combinational so releasing CE_N/OE_N frees the bus at once.
    assign w_dq_oe = (r_state == RD_DRIVE) & ~bus.SRAM_CE_N & ~bus.SRAM_OE_N & bus.SRAM_WE_N;
    assign SRAM_DQ = w_dq_oe ? r_rd_data : 'z;

    assign bus.busy      = (r_state != IDLE);
    assign bus.proto_err = r_proto_err;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// writes/reads compared against a word-array reference model.
module tb_sram_responder;

    localparam int unsigned DEPTH  = 65536;
    localparam int unsigned RD_LAT = 2;
    localparam logic [15:0] ZVAL   = 16'hFFFF;   // undriven bus reads as pulled-up

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wire  [15:0] w_dq;
    logic        r_tb_oe = 1'b0;
    logic [15:0] r_tb_dq = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: word contents by array index.
    logic [15:0] m_mem [int unsigned];

    always #5 clk = ~clk;

    assign w_dq = r_tb_oe ? r_tb_dq : 16'hzzzz;
    pullup pu_dq (w_dq);

    sram_responder_if u_if ();

    sram_responder #(
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .SRAM_DQ (w_dq),
        .bus     (u_if.slave)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        u_if.SRAM_CE_N = 1'b1;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b1;
        u_if.SRAM_UB_N = 1'b0;
        u_if.SRAM_LB_N = 1'b0;
        r_tb_oe        = 1'b0;
    endtask

    function automatic int unsigned m_idx(input logic [17:0] a);
        return int'(a) % DEPTH;
    endfunction

    function automatic logic [15:0] m_get(input logic [17:0] a);
        if (m_mem.exists(m_idx(a))) return m_mem[m_idx(a)];
        return 16'h0000;
    endfunction

    task automatic m_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
        logic [15:0] w;
        w = m_get(a);
        if (!ub_n) w[15:8] = d[15:8];
        if (!lb_n) w[7:0]  = d[7:0];
        m_mem[m_idx(a)] = w;
    endtask

    function automatic logic [15:0] m_read(input logic [17:0] a, input logic ub_n, input logic lb_n);
        logic [15:0] w;
        w = m_get(a);
        if (ub_n) w[15:8] = 8'h00;
        if (lb_n) w[7:0]  = 8'h00;
        return w;
    endfunction

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
        u_if.SRAM_ADDR = a;
        u_if.SRAM_UB_N = ub_n;
        u_if.SRAM_LB_N = lb_n;
        u_if.SRAM_OE_N = 1'b1;
        u_if.SRAM_WE_N = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        r_tb_dq        = d;
        r_tb_oe        = 1'b1;
        tick();
        chk_eq("wr_perr", 32'(u_if.proto_err), 32'd0);
        chk_eq("wr_busy", 32'(u_if.busy), 32'd1);
        m_write(a, d, ub_n, lb_n);
        set_idle();
    endtask

    task automatic rd(input logic [17:0] a, input logic ub_n, input logic lb_n);
        logic [15:0] exp;
        exp = m_read(a, ub_n, lb_n);
        u_if.SRAM_ADDR = a;
        u_if.SRAM_UB_N = ub_n;
        u_if.SRAM_LB_N = lb_n;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        r_tb_oe        = 1'b0;
        #1;
        if (exp != ZVAL) chk_eq("rd_z_pre", 32'(w_dq), 32'(ZVAL));
        for (int e = 1; e <= int'(RD_LAT); e++) begin
            tick();
            chk_eq("rd_busy", 32'(u_if.busy), 32'd1);
            if (e < int'(RD_LAT)) begin
                if (exp != ZVAL) chk_eq("rd_z_wait", 32'(w_dq), 32'(ZVAL));
            end else begin
                chk_eq("rd_data", 32'(w_dq), 32'(exp));
            end
        end
        tick();
        chk_eq("rd_hold", 32'(w_dq), 32'(exp));
        set_idle();
        #1;
        if (exp != ZVAL) chk_eq("rd_release", 32'(w_dq), 32'(ZVAL));
        tick();
        chk_eq("rd_idle_busy", 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        logic [17:0] pool [8];
        logic [15:0] d;
        int unsigned exp_cnt;

        u_if.SRAM_ADDR = '0;
        set_idle();

        // Reset state
        tick();
        chk_eq("rst_busy", 32'(u_if.busy), 32'd0);
        chk_eq("rst_perr", 32'(u_if.proto_err), 32'd0);
        chk_eq("rst_errcnt", 32'(u_if.err_count), 32'd0);
        chk_eq("rst_dq_z", 32'(w_dq), 32'(ZVAL));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Basic write/read-back with latency and bus release
        wr(18'h00010, 16'hA5C3, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0);

        // Byte-lane write and lane-masked reads
        wr(18'h00005, 16'h1234, 1'b0, 1'b0);
        wr(18'h00005, 16'hFFFF, 1'b1, 1'b0);
        chk_eq("lane_model", 32'(m_get(18'h5)), 32'h12FF);
        rd(18'h00005, 1'b0, 1'b0);
        rd(18'h00005, 1'b0, 1'b1);

        // Address change during RD_WAIT restarts latency
        wr(18'h00006, 16'h6A6A, 1'b0, 1'b0);
        u_if.SRAM_ADDR = 18'h00005;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        tick();
        chk_eq("chg_z0", 32'(w_dq), 32'(ZVAL));
        u_if.SRAM_ADDR = 18'h00006;
        tick();
        chk_eq("chg_z1", 32'(w_dq), 32'(ZVAL));
        chk_eq("chg_busy", 32'(u_if.busy), 32'd1);
        tick();
        chk_eq("chg_data", 32'(w_dq), 32'(m_get(18'h6)));
        set_idle();
        tick();

        // CE_N high: write attempt ignored, no error, stays idle
        u_if.SRAM_ADDR = 18'h00005;
        u_if.SRAM_WE_N = 1'b0;
        u_if.SRAM_OE_N = 1'b0;
        r_tb_dq        = 16'h0BAD;
        r_tb_oe        = 1'b1;
        tick();
        chk_eq("ceoff_perr", 32'(u_if.proto_err), 32'd0);
        chk_eq("ceoff_busy", 32'(u_if.busy), 32'd0);
        set_idle();
        rd(18'h00005, 1'b0, 1'b0);

        // Illegal WE_N=OE_N=0 held: per-cycle error, saturating count, write kept
        u_if.SRAM_ADDR = 18'h00020;
        u_if.SRAM_WE_N = 1'b0;
        u_if.SRAM_OE_N = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        r_tb_dq        = 16'hBEEF;
        r_tb_oe        = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            exp_cnt = (i > 255) ? 255 : i;
            chk_eq("perr_pulse", 32'(u_if.proto_err), 32'd1);
            chk_eq("perr_count", 32'(u_if.err_count), exp_cnt);
            chk_eq("perr_dq", 32'(w_dq), 32'hBEEF);
        end
        m_write(18'h00020, 16'hBEEF, 1'b0, 1'b0);
        set_idle();
        tick();
        chk_eq("perr_clear", 32'(u_if.proto_err), 32'd0);
        chk_eq("perr_hold", 32'(u_if.err_count), 32'hFF);
        rd(18'h00020, 1'b0, 1'b0);

        // Aliased addresses map to one word
        wr(18'h00003, 16'h3C5A, 1'b0, 1'b0);
        rd(18'h10003, 1'b0, 1'b0);
        wr(18'h10003, 16'h7E81, 1'b0, 1'b0);
        rd(18'h00003, 1'b0, 1'b0);

        // Asynchronous reset during RD_DRIVE
        u_if.SRAM_ADDR = 18'h00010;
        u_if.SRAM_WE_N = 1'b1;
        u_if.SRAM_OE_N = 1'b0;
        u_if.SRAM_CE_N = 1'b0;
        tick();
        tick();
        chk_eq("arst_pre_dq", 32'(w_dq), 32'(m_get(18'h10)));
        #2;
        rst = 1'b0;
        #1;
        chk_eq("arst_dq_z", 32'(w_dq), 32'(ZVAL));
        chk_eq("arst_busy", 32'(u_if.busy), 32'd0);
        chk_eq("arst_errcnt", 32'(u_if.err_count), 32'd0);
        tick();
        chk_eq("arst_held_busy", 32'(u_if.busy), 32'd0);
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rd(18'h00010, 1'b0, 1'b0);
        rd(18'h00005, 1'b0, 1'b0);

        // Randomized traffic over a small address pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = {2'($urandom_range(0, 3)), 16'($urandom)};
            d       = 16'($urandom_range(0, 16'hFFFE));
            wr(pool[i], d, 1'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            int unsigned k;
            logic [17:0] a;
            k = $urandom_range(0, 7);
            a = {2'($urandom_range(0, 3)), pool[k][15:0]};
            if ($urandom_range(0, 1) == 0) begin
                wr(a, 16'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                rd(a, 1'($urandom), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH, default 65536: number of 16-bit words stored; power of two.
REQ-002 Parameter RD_LAT, default 2: clock edges from read-request sample to data driven; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-005 SRAM_DQ  inout  16  bidirectional data bus; driven only per REQ-014, else high-Z.
REQ-006 SRAM_ADDR  input  18  word address from memory-stage controller.
REQ-007 SRAM_WE_N  input  1  write enable, active-low.
REQ-008 SRAM_UB_N  input  1  upper byte lane [15:8] enable, active-low.
REQ-009 SRAM_LB_N  input  1  lower byte lane [7:0] enable, active-low.
REQ-010 SRAM_CE_N  input  1  chip enable, active-low; when 1 all other controls are ignored.
REQ-011 SRAM_OE_N  input  1  output enable, active-low.
REQ-012 busy  output  1  1 when FSM not in IDLE.
REQ-013 proto_err  output  1  one-cycle pulse on illegal control combination; err_count  output  8  saturating count of proto_err pulses.

Function
REQ-014 DQ drive enable SHALL be combinational: state==RD_DRIVE & ~CE_N & ~OE_N & WE_N; driven value = registered rd_data; otherwise 16'hzzzz.
REQ-015 Array index SHALL be SRAM_ADDR[log2(DEPTH)-1:0]; upper address bits ignored (aliasing, no error).
REQ-016 FSM states: IDLE, RD_WAIT, RD_DRIVE, WR; all inputs sampled on rising clk.
REQ-017 Any state, CE_N=0 & WE_N=0 sampled: write DQ[15:8] if UB_N=0 and DQ[7:0] if LB_N=0 into addressed word; next state WR; write takes priority over read.
REQ-018 WR: each further edge with CE_N=0 & WE_N=0 repeats the write at current address/data; otherwise behave as IDLE for that edge.
REQ-019 IDLE, CE_N=0 & WE_N=1 & OE_N=0: latch address into rd_addr; RD_LAT=1 -> load rd_data, go RD_DRIVE; else load counter RD_LAT-1, go RD_WAIT.
REQ-020 RD_WAIT: counter decrements per edge; on edge where counter==1, load rd_data=mem[rd_addr] with disabled byte lanes forced to 8'h00, go RD_DRIVE.
REQ-021 RD_WAIT/RD_DRIVE: SRAM_ADDR != rd_addr with read still requested -> relatch address, restart latency (RD_WAIT, or RD_DRIVE with fresh data if RD_LAT=1).
REQ-022 RD_WAIT/RD_DRIVE: CE_N=1 or OE_N=1 (and no write) -> IDLE, read abandoned, DQ high-Z.
REQ-023 RD_DRIVE holds while request and address unchanged; rd_data reflects a write to the same address only after a new read request.
REQ-024 CE_N=0 & WE_N=0 & OE_N=0 sampled: proto_err=1 for that cycle; err_count increments, saturates at 8'hFF; write still performed.
REQ-025 CE_N=1: no write, no read, no proto_err; FSM -> IDLE.

Reset
REQ-026 rst=0: state IDLE, counter 0, rd_addr 0, rd_data 0, busy 0, proto_err 0, err_count 0, DQ high-Z, all within the same cycle (asynchronous).
REQ-027 Array contents SHALL NOT be reset; reset mid-read abandons the read; reset mid-write leaves previously written words intact.

Verification
REQ-028 Write addr 18'h00010 data 16'hA5C3, UB_N=LB_N=0; read back with RD_LAT=2 -> DQ high-Z for 1 cycle after request, 16'hA5C3 driven from second edge, busy=1 throughout.
REQ-029 Pre-write 16'h1234 at addr 5; write 16'hFFFF with UB_N=1, LB_N=0 -> read returns 16'h12FF; read with UB_N=0, LB_N=1 -> 16'h1200.
REQ-030 Read addr 5 then change SRAM_ADDR to 6 during RD_WAIT -> latency restarts, DQ shows mem[6] RD_LAT edges after change, mem[5] never driven.
REQ-031 Hold CE_N=WE_N=OE_N=0 for 300 cycles -> proto_err high each sampled cycle, err_count stops at 8'hFF, DQ never driven, write data stored.
REQ-032 Assert rst=0 during RD_DRIVE -> DQ high-Z and busy=0 immediately without clock; after release, previously written data still readable.
REQ-033 Addresses 18'h00003 and 18'h10003 with DEPTH=65536 -> alias to same word; write via one, read via other returns identical data.
